// File: rtl/bus_pkg.sv
// Shared constants, state encoding and page-decode helper
// for the VRAM system-bus arbiter and its sub-blocks.
package bus_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam logic [3:0] VRAM_PAGE = 4'h4;

    localparam int VRAM_SEL_HI = 11;
    localparam int VRAM_SEL_LO = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    function automatic logic page_hit(
        input logic [3:0] sel,
        input logic [3:0] page
    );
        return sel == page;
    endfunction

endpackage

// File: rtl/vram_bus_arbiter_if.sv
// Per-master request/grant bundle of the VRAM bus arbiter.
// master: req/we/addr/wdata out, gnt/ack/rdata in; slave: reverse.
interface vram_bus_arbiter_if #(
    parameter int ADDR_W = bus_pkg::ADDR_W,
    parameter int DATA_W = bus_pkg::DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, ack, rdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: i_elig eligibility, i_rr_last last
// winner index; o_win one-hot winner (2'b00 when nobody eligible).
module rr_arbiter2 (
    input  logic [1:0] i_elig,
    input  logic       i_rr_last,
    output logic [1:0] o_win
);

    always_comb begin
        o_win = 2'b00;
        if (&i_elig) begin
            // tie goes to whoever did not win last time
            o_win = i_rr_last ? 2'b01 : 2'b10;
        end else begin
            o_win = i_elig;
        end
    end

endmodule

// File: rtl/vram_bus_arbiter.sv
// Two-master system-bus arbiter with read/write strobe sequencing,
// video-page decode and optional vblank-only video writes.
// Ports: clk, reset (sync, active-low), vblank; m0/m1 master
// bundles; bus_addr/bus_wdata/bus_we/bus_oe/bus_rdata system bus;
// video_we/video_oe page-decoded strobes; busy = not idle.
module vram_bus_arbiter #(
    parameter int         ADDR_W      = bus_pkg::ADDR_W,
    parameter int         DATA_W      = bus_pkg::DATA_W,
    parameter int         READ_LAT    = 1,
    parameter logic [3:0] VRAM_PAGE   = bus_pkg::VRAM_PAGE,
    parameter bit         VBLANK_ONLY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vblank,
    vram_bus_arbiter_if.slave m0,
    vram_bus_arbiter_if.slave m1,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              video_we,
    output logic              video_oe,
    output logic              busy
);
    import bus_pkg::*;

    localparam int LAT_W =
        (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t            r_state;
    state_t            w_next;
    logic              r_idx;
    logic              r_rr_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [LAT_W-1:0]  r_lat;
    logic [DATA_W-1:0] r_rdata [2];

    logic       w_gate0;
    logic       w_gate1;
    logic [1:0] w_elig;
    logic [1:0] w_win;
    logic       w_grant;
    logic       w_lat_done;
    logic       w_bus_page;

    // a video write outside vblank is held off, never rejected
    assign w_gate0 = VBLANK_ONLY && m0.we && !vblank &&
        page_hit(m0.addr[VRAM_SEL_HI:VRAM_SEL_LO], VRAM_PAGE);
    assign w_gate1 = VBLANK_ONLY && m1.we && !vblank &&
        page_hit(m1.addr[VRAM_SEL_HI:VRAM_SEL_LO], VRAM_PAGE);

    assign w_elig = {m1.req & ~w_gate1, m0.req & ~w_gate0};

    rr_arbiter2 u_rr (
        .i_elig    (w_elig),
        .i_rr_last (r_rr_last),
        .o_win     (w_win)
    );

    assign w_grant    = (r_state == IDLE) && (|w_win);
    assign w_lat_done = (r_lat == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (|w_win) w_next = ADDR;
            ADDR: w_next = (r_we || w_lat_done) ? ACK : WAIT;
            WAIT: if (w_lat_done) w_next = ACK;
            ACK:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx      <= 1'b0;
            r_rr_last  <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lat      <= '0;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
        end else begin
            if (w_grant) begin
                r_idx     <= w_win[1];
                r_rr_last <= w_win[1];
                r_we      <= w_win[1] ? m1.we : m0.we;
                r_addr    <= w_win[1] ? m1.addr : m0.addr;
                r_wdata   <= w_win[1] ? m1.wdata : m0.wdata;
                r_lat     <= LAT_W'(READ_LAT - 1);
            end
            if (bus_oe && !w_lat_done) begin
                r_lat <= r_lat - 1'b1;
            end
            // capture on the final strobe cycle only
            if (bus_oe && w_lat_done) begin
                r_rdata[r_idx] <= bus_rdata;
            end
        end
    end

    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_we    = (r_state == ADDR) && r_we;
    assign bus_oe    = ((r_state == ADDR) ||
                        (r_state == WAIT)) && !r_we;

    assign w_bus_page =
        page_hit(r_addr[VRAM_SEL_HI:VRAM_SEL_LO], VRAM_PAGE);
    assign video_we = bus_we && w_bus_page;
    assign video_oe = bus_oe && w_bus_page;

    assign busy = (r_state != IDLE);

    assign m0.gnt   = busy && !r_idx;
    assign m1.gnt   = busy && r_idx;
    assign m0.ack   = (r_state == ACK) && !r_idx;
    assign m1.ack   = (r_state == ACK) && r_idx;
    assign m0.rdata = r_rdata[0];
    assign m1.rdata = r_rdata[1];

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Scoreboard bench for vram_bus_arbiter: directed scenarios then
// randomized two-master traffic against a timeline reference model.
module tb_vram_bus_arbiter;

    localparam int RL = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic vblank;

    always #5 clk = ~clk;

    vram_bus_arbiter_if #(.ADDR_W(12), .DATA_W(8)) if0 ();
    vram_bus_arbiter_if #(.ADDR_W(12), .DATA_W(8)) if1 ();

    logic [11:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_we;
    logic        bus_oe;
    logic        video_we;
    logic        video_oe;
    logic        busy;

    vram_bus_arbiter #(
        .ADDR_W      (12),
        .DATA_W      (8),
        .READ_LAT    (RL),
        .VRAM_PAGE   (4'h4),
        .VBLANK_ONLY (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .vblank    (vblank),
        .m0        (if0),
        .m1        (if1),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_oe    (bus_oe),
        .bus_rdata (bus_rdata),
        .video_we  (video_we),
        .video_oe  (video_oe),
        .busy      (busy)
    );

    // slave ROM: correct data only on the last strobe cycle
    logic [7:0] mem [0:4095];
    int oe_cnt = 0;
    always @(posedge clk) oe_cnt <= bus_oe ? oe_cnt + 1 : 0;
    assign bus_rdata = (bus_oe && oe_cnt == RL - 1) ?
        mem[bus_addr] : ~mem[bus_addr];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [7:0]  rdata;
        int          g_cyc;
        int          ack_cyc;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    // reference model state
    int          cyc = 0;
    int          next_arb = 0;
    bit          model_on = 0;
    bit          rr_last = 1;
    bit          have_cur = 0;
    int          cur_idx = 0;
    txn_t        cur;
    logic [11:0] hold_addr = '0;
    logic [7:0]  hold_wdata = '0;
    logic [7:0]  last_rd [2];

    function automatic bit elig(input bit r, input bit we,
                                input logic [11:0] a,
                                input bit vb);
        return r && !(we && a[11:8] == 4'h4 && !vb);
    endfunction

    initial begin : model
        bit   e0;
        bit   e1;
        int   w;
        txn_t t;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                model_on = 1;
                if (have_cur && cyc <= cur.ack_cyc) begin
                    if (cur_idx == 0) void'(q0.pop_back());
                    else void'(q1.pop_back());
                end
                have_cur = 0;
                next_arb = 0;
                rr_last = 1;
                hold_addr = '0;
                hold_wdata = '0;
                last_rd[0] = '0;
                last_rd[1] = '0;
            end else if (model_on && cyc >= next_arb) begin
                e0 = elig(if0.req, if0.we, if0.addr, vblank);
                e1 = elig(if1.req, if1.we, if1.addr, vblank);
                if (e0 || e1) begin
                    if (e0 && e1) w = rr_last ? 0 : 1;
                    else w = e1 ? 1 : 0;
                    t.we = (w == 0) ? if0.we : if1.we;
                    t.addr = (w == 0) ? if0.addr : if1.addr;
                    hold_wdata = (w == 0) ? if0.wdata
                                          : if1.wdata;
                    if (!t.we) last_rd[w] = mem[t.addr];
                    t.rdata = last_rd[w];
                    t.g_cyc = cyc;
                    t.ack_cyc = t.we ? cyc + 1 : cyc + RL;
                    if (w == 0) q0.push_back(t);
                    else q1.push_back(t);
                    cur = t;
                    cur_idx = w;
                    have_cur = 1;
                    rr_last = (w == 1);
                    hold_addr = t.addr;
                    next_arb = t.ack_cyc + 2;
                end
            end
        end
    end

    // per-cycle bus check plus ack scoreboard
    initial begin : monitor
        logic [28:0] ev;
        logic [28:0] gv;
        bit          act;
        bit          ewe;
        bit          eoe;
        bit          eack;
        bit          pg;
        bit          a;
        txn_t        t;
        logic [7:0]  rd;
        forever begin
            @(negedge clk);
            if (model_on) begin
                act = have_cur && cyc >= cur.g_cyc &&
                      cyc <= cur.ack_cyc;
                ewe = act && cur.we && cyc == cur.g_cyc;
                eoe = act && !cur.we && cyc < cur.ack_cyc;
                eack = act && cyc == cur.ack_cyc;
                pg = hold_addr[11:8] == 4'h4;
                ev = {act && cur_idx == 0, act && cur_idx == 1,
                      eack && cur_idx == 0, eack && cur_idx == 1,
                      ewe, eoe, ewe && pg, eoe && pg, act,
                      hold_addr, hold_wdata};
                gv = {if0.gnt, if1.gnt, if0.ack, if1.ack,
                      bus_we, bus_oe, video_we, video_oe, busy,
                      bus_addr, bus_wdata};
                checks++;
                if (gv !== ev) begin
                    errors++;
                    $display("FAIL bus cyc=%0d got=%h exp=%h",
                             cyc, gv, ev);
                end
                for (int m = 0; m < 2; m++) begin
                    a = (m == 0) ? if0.ack : if1.ack;
                    rd = (m == 0) ? if0.rdata : if1.rdata;
                    if (a) begin
                        checks++;
                        if ((m == 0 && q0.size() == 0) ||
                            (m == 1 && q1.size() == 0)) begin
                            errors++;
                            $display("FAIL ack_unexp m%0d cyc=%0d",
                                     m, cyc);
                        end else begin
                            t = (m == 0) ? q0.pop_front()
                                         : q1.pop_front();
                            if (cyc != t.ack_cyc ||
                                rd !== t.rdata) begin
                                errors++;
                                $display({"FAIL ack m%0d a=%h ",
                                          "cyc=%0d/%0d rd=%h/%h"},
                                         m, t.addr, cyc,
                                         t.ack_cyc, rd, t.rdata);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic set_req(input int m, input bit r,
                           input bit we,
                           input logic [11:0] a,
                           input logic [7:0] d);
        if (m == 0) begin
            if0.req = r; if0.we = we;
            if0.addr = a; if0.wdata = d;
        end else begin
            if1.req = r; if1.we = we;
            if1.addr = a; if1.wdata = d;
        end
    endtask

    task automatic wait_ack(input int m, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = (m == 0) ? if0.ack : if1.ack;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout m%0d got=0 exp=1", m);
        end
    endtask

    function automatic logic [11:0] rnd_addr(input bit video);
        logic [11:0] a = 12'($urandom);
        if (video) a[11:8] = 4'h4;
        else if (a[11:8] == 4'h4) a[11] = 1'b1;
        return a;
    endfunction

    // mode 0: back-to-back non-video writes; mode 1: random mix
    task automatic run_master(input int m, input int n,
                              input int mode);
        bit          we;
        logic [11:0] a;
        int          gap;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
                we = 1;
                a = rnd_addr(0);
            end else begin
                gap = $urandom_range(0, 3);
                if (gap != 0) begin
                    set_req(m, 0, 0, 12'h0, 8'h0);
                    repeat (gap) @(negedge clk);
                end
                we = 1'($urandom);
                a = rnd_addr($urandom_range(0, 9) < 3);
            end
            set_req(m, 1, we, a, 8'($urandom));
            wait_ack(m, 400);
        end
        set_req(m, 0, 0, 12'h0, 8'h0);
    endtask

    bit rand_done = 0;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h123] = 8'h3C;
        rst_n = 1'b0;
        vblank = 1'b1;
        set_req(1, 0, 0, 12'h0, 8'h0);
        // request held through reset
        set_req(0, 1, 1, 12'h405, 8'hA5);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ack(0, 20);
        set_req(0, 0, 0, 12'h0, 8'h0);

        @(negedge clk);
        set_req(1, 1, 0, 12'h123, 8'h00);
        wait_ack(1, 20);
        set_req(1, 0, 0, 12'h0, 8'h0);

        fork
            run_master(0, 6, 0);
            run_master(1, 6, 0);
        join

        @(negedge clk);
        vblank = 1'b0;
        set_req(1, 1, 1, 12'h410, 8'h77);
        set_req(0, 1, 0, 12'h010, 8'h00);
        wait_ack(0, 20);
        set_req(0, 0, 0, 12'h0, 8'h0);
        repeat (6) @(negedge clk);
        vblank = 1'b1;
        wait_ack(1, 20);
        set_req(1, 0, 0, 12'h0, 8'h0);

        // reset while a read sits in its wait phase
        @(negedge clk);
        set_req(0, 1, 0, 12'h200, 8'h00);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = if0.gnt;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL gnt_timeout got=0 exp=1");
        end
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 0, 0, 12'h0, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        fork
            begin
                fork
                    run_master(0, 40, 1);
                    run_master(1, 40, 1);
                join
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    repeat ($urandom_range(3, 25)) @(negedge clk);
                    vblank = ~vblank;
                end
                vblank = 1'b1;
            end
        join

        repeat (5) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL leftover got=%0d exp=0",
                     q0.size() + q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_bus_arbiter.md
Name: vram_bus_arbiter

Overview:
- Shares the 12-bit address / 8-bit data system bus between two masters: m0 (CPU) and m1 (vsync-driven updater/DMA).
- Sequences each access into single-cycle write strobes or multi-cycle read strobes.
- Decodes the video page (0x4xx) into video_we/video_oe for the text buffer.
- Optionally defers video-page writes until vertical blank, so the text buffer is never modified mid-frame.

Parameters:
- ADDR_W, 12, bus address width
- DATA_W, 8, bus data width
- READ_LAT, 1, cycles bus_oe is held before bus_rdata is sampled; must be at least 1
- VRAM_PAGE, 4'h4, value of addr[11:8] that selects video memory
- VBLANK_ONLY, 1, 1 = grant video-page writes only while vblank=1

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- vblank  in  1  high during vertical blank (from LCD timing)
- m0_req  in  1  m0 requests access; held until m0_ack
- m0_we  in  1  1 = write, 0 = read; stable while m0_req
- m0_addr  in  ADDR_W  access address; stable while m0_req
- m0_wdata  in  DATA_W  write data; stable while m0_req
- m0_gnt  out  1  m0 owns the bus (ADDR..ACK)
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data; valid while m0_ack=1
- m1_req / m1_we / m1_addr / m1_wdata / m1_gnt / m1_ack / m1_rdata  same as m0
- bus_addr  out  ADDR_W  registered address
- bus_wdata  out  DATA_W  registered write data
- bus_we  out  1  write strobe
- bus_oe  out  1  read strobe
- bus_rdata  in  DATA_W  read data from the addressed slave
- video_we  out  1  bus_we & (bus_addr[11:8]==VRAM_PAGE)
- video_oe  out  1  bus_oe & (bus_addr[11:8]==VRAM_PAGE)
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; all outputs 0, including bus_addr and bus_wdata; rr_last=1, so m0 wins the first tie. Reset mid-transaction aborts it with no ack.
- Eligibility: mX is eligible if mX_req=1, unless VBLANK_ONLY=1 and mX_we=1 and mX_addr[11:8]==VRAM_PAGE and vblank=0. Reads and non-video writes are never gated.
- Arbitration runs only in IDLE:
  - One eligible master: it wins.
  - Both eligible: the master not equal to rr_last wins (round-robin).
  - The winner's addr/we/wdata/index are latched; mX_gnt=1; rr_last=winner.
- FSM:
  - IDLE -> ADDR on a grant; stays in IDLE if no master is eligible.
  - ADDR, write: bus_we=1 for exactly this one cycle -> ACK.
  - ADDR, read: bus_oe=1; lat_cnt=READ_LAT-1; -> ACK if lat_cnt==0, else WAIT.
  - WAIT: bus_oe=1; lat_cnt decrements each cycle; -> ACK when lat_cnt==0.
  - On the last bus_oe cycle, bus_rdata is registered into the granted master's rdata.
  - ACK: bus_we=bus_oe=0; mX_ack=1 for one cycle; mX_gnt=1 remains through this cycle; -> IDLE.
- Latency, request seen to ack: write 2 cycles; read READ_LAT+1 cycles. IDLE costs one cycle between transactions.
- mX_rdata holds its last value after ack; only reads update it.
- Gating is evaluated only at grant. vblank falling after grant does not abort the access.
- mX_req dropping mid-transaction is a protocol violation. The transaction still completes and acks.
- A master that keeps req high after ack is re-arbitrated in the next IDLE. Round-robin prevents it from starving the other master.
- A gated master never blocks the other master's eligible requests.
- bus_addr and bus_wdata hold their values after ACK until the next grant. Only the strobes return to 0.
- video_we and video_oe are combinational from the registered bus outputs, so they are glitch-free.

Decomposition:
- Shared package (bus_pkg):
  - ADDR_W, DATA_W, VRAM_PAGE
  - state encoding: IDLE=0, ADDR=1, WAIT=2, ACK=3
  - helper constant VRAM_SEL_HI=11, VRAM_SEL_LO=8
- Sub-module rr_arbiter2: eligibility vector plus rr_last in, one-hot winner out; purely combinational; reused by future sprite/DMA arbitration.

Test Plan:
- Reset: hold reset=0 3 cycles while m0_req=1 -> all outputs 0, busy=0. After release, m0_gnt rises 1 cycle later.
- m0 writes 0x405<=0xA5 with vblank=1 -> bus_we and video_we high for exactly 1 cycle with bus_addr=0x405, bus_wdata=0xA5. m0_ack pulses 2 cycles after req.
- READ_LAT=3, m1 reads 0x123 with bus_rdata=0x3C -> bus_oe high 3 cycles, video_oe=0. m1_ack at cycle 4 with m1_rdata=0x3C.
- Both masters continuously write non-video addresses -> grants alternate m0, m1, m0, m1. Each ack is separated by 3 cycles.
- m1 writes 0x410 with vblank=0 while m0 reads 0x010 -> m0 is served and m1 waits. Raise vblank -> m1 is granted next IDLE; video_we=1 for one cycle.
- Assert reset=0 in the WAIT state of a read -> no ack is issued; state returns to IDLE; bus_oe=0 on the next edge.
